// File: rtl/minirisc_bus_arbiter.sv
// N-master arbiter for the MiniRISC data-memory bus.
// Round-robin or fixed priority, with optional bounded tenure.
module minirisc_bus_arbiter #(
    parameter int NUM_MST   = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_MST-1:0]         mst_req,
    output logic [NUM_MST-1:0]         mst_grant,
    input  logic [NUM_MST*ADDR_W-1:0]  mst_addr,
    input  logic [NUM_MST-1:0]         mst_wr,
    input  logic [NUM_MST-1:0]         mst_rd,
    input  logic [NUM_MST*DATA_W-1:0]  mst_wdata,
    output logic [DATA_W-1:0]          mst_rdata,
    output logic [ADDR_W-1:0]          slv_addr,
    output logic                       slv_wr,
    output logic                       slv_rd,
    output logic [DATA_W-1:0]          slv_wdata,
    input  logic [DATA_W-1:0]          slv_rdata,
    output logic [$clog2(NUM_MST)-1:0] owner,
    output logic                       busy
);

    localparam int OW = $clog2(NUM_MST);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state, state_n;
    logic [NUM_MST-1:0] grant_n, cand, owner_oh;
    logic [OW-1:0]      owner_n, rr_ptr, rr_n, win;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic               found, other, own_busy, preempt, grab;

    // The current owner is masked out so a preempted master cannot re-win.
    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        cand  = (state == OWNED) ? (mst_req & ~owner_oh) : mst_req;
        other = |cand;
        win   = '0;
        found = 1'b0;
        if (PRIO_MODE != 0) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (!found && cand[i]) begin
                    win   = OW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MST; k++) begin
                if (!found && cand[(int'(rr_ptr) + k) % NUM_MST]) begin
                    win   = OW'((int'(rr_ptr) + k) % NUM_MST);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = mst_grant;
        owner_n  = owner;
        rr_n     = rr_ptr;
        hold_n   = hold_cnt;
        grab     = 1'b0;
        own_busy = mst_wr[owner] | mst_rd[owner];
        preempt  = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD - 1)
                   && other && !own_busy;
        unique case (state)
            IDLE: grab = other;
            OWNED: begin
                if (!mst_req[owner] || preempt) begin
                    if (other) begin
                        grab = 1'b1;
                    end else begin
                        grant_n = '0;
                        hold_n  = '0;
                        state_n = IDLE;
                    end
                end else if (other) begin
                    if (int'(hold_cnt) < MAX_HOLD - 1)
                        hold_n = hold_cnt + 1'b1;
                end else begin
                    hold_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (grab) begin
            grant_n      = '0;
            grant_n[win] = 1'b1;
            owner_n      = win;
            rr_n         = win;
            hold_n       = '0;
            state_n      = OWNED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mst_grant <= '0;
            owner     <= '0;
            rr_ptr    <= OW'(NUM_MST - 1);
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            mst_grant <= grant_n;
            owner     <= owner_n;
            rr_ptr    <= rr_n;
            hold_cnt  <= hold_n;
        end
    end

    // Grant is one-hot or zero, so OR-ing the gated masters is a clean mux.
    always_comb begin
        slv_addr  = '0;
        slv_wr    = 1'b0;
        slv_rd    = 1'b0;
        slv_wdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (mst_grant[i]) begin
                slv_addr  = slv_addr | mst_addr[i*ADDR_W +: ADDR_W];
                slv_wr    = slv_wr | mst_wr[i];
                slv_rd    = slv_rd | mst_rd[i];
                slv_wdata = slv_wdata | mst_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign mst_rdata = slv_rdata;
    assign busy      = |mst_grant;

endmodule

// File: tb/tb_minirisc_bus_arbiter.sv
// Directed bench for minirisc_bus_arbiter across four configurations.
// Ends with a random fairness and mux-consistency sweep at NUM_MST=8.
module tb_minirisc_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // u2: 2 masters, round-robin, unlimited tenure
    logic [1:0]  req2, grant2, wr2, rd2;
    logic [15:0] addr2, wdata2;
    logic [7:0]  rdata2, saddr2, swdata2, srdata2;
    logic        swr2, srd2, busy2;
    logic [0:0]  owner2;

    minirisc_bus_arbiter #(.NUM_MST(2), .PRIO_MODE(0), .MAX_HOLD(0)) u2 (
        .clk(clk), .rst_n(rst_n), .mst_req(req2), .mst_grant(grant2),
        .mst_addr(addr2), .mst_wr(wr2), .mst_rd(rd2), .mst_wdata(wdata2),
        .mst_rdata(rdata2), .slv_addr(saddr2), .slv_wr(swr2), .slv_rd(srd2),
        .slv_wdata(swdata2), .slv_rdata(srdata2), .owner(owner2), .busy(busy2)
    );

    // u4: 4 masters, fixed priority
    logic [3:0]  req4, grant4, wr4, rd4;
    logic [31:0] addr4, wdata4;
    logic [7:0]  rdata4, saddr4, swdata4, srdata4;
    logic        swr4, srd4, busy4;
    logic [1:0]  owner4;

    minirisc_bus_arbiter #(.NUM_MST(4), .PRIO_MODE(1), .MAX_HOLD(0)) u4 (
        .clk(clk), .rst_n(rst_n), .mst_req(req4), .mst_grant(grant4),
        .mst_addr(addr4), .mst_wr(wr4), .mst_rd(rd4), .mst_wdata(wdata4),
        .mst_rdata(rdata4), .slv_addr(saddr4), .slv_wr(swr4), .slv_rd(srd4),
        .slv_wdata(swdata4), .slv_rdata(srdata4), .owner(owner4), .busy(busy4)
    );

    // uh: 2 masters, round-robin, MAX_HOLD=4
    logic [1:0]  reqh, granth, wrh, rdh;
    logic [15:0] addrh, wdatah;
    logic [7:0]  rdatah, saddrh, swdatah, srdatah;
    logic        swrh, srdh, busyh;
    logic [0:0]  ownerh;

    minirisc_bus_arbiter #(.NUM_MST(2), .PRIO_MODE(0), .MAX_HOLD(4)) uh (
        .clk(clk), .rst_n(rst_n), .mst_req(reqh), .mst_grant(granth),
        .mst_addr(addrh), .mst_wr(wrh), .mst_rd(rdh), .mst_wdata(wdatah),
        .mst_rdata(rdatah), .slv_addr(saddrh), .slv_wr(swrh), .slv_rd(srdh),
        .slv_wdata(swdatah), .slv_rdata(srdatah), .owner(ownerh), .busy(busyh)
    );

    // u8: 8 masters, round-robin, default tenure
    logic [7:0]  req8, grant8, wr8, rd8;
    logic [63:0] addr8, wdata8;
    logic [7:0]  rdata8, saddr8, swdata8, srdata8;
    logic        swr8, srd8, busy8;
    logic [2:0]  owner8;

    minirisc_bus_arbiter #(.NUM_MST(8), .PRIO_MODE(0), .MAX_HOLD(16)) u8 (
        .clk(clk), .rst_n(rst_n), .mst_req(req8), .mst_grant(grant8),
        .mst_addr(addr8), .mst_wr(wr8), .mst_rd(rd8), .mst_wdata(wdata8),
        .mst_rdata(rdata8), .slv_addr(saddr8), .slv_wr(swr8), .slv_rd(srd8),
        .slv_wdata(swdata8), .slv_rdata(srdata8), .owner(owner8), .busy(busy8)
    );

    task automatic zero_inputs();
        req2 = '0; wr2 = '0; rd2 = '0; addr2 = '0; wdata2 = '0; srdata2 = '0;
        req4 = '0; wr4 = '0; rd4 = '0; addr4 = '0; wdata4 = '0; srdata4 = '0;
        reqh = '0; wrh = '0; rdh = '0; addrh = '0; wdatah = '0; srdatah = '0;
        req8 = '0; wr8 = '0; rd8 = '0; addr8 = '0; wdata8 = '0; srdata8 = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        zero_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] prev_g, req_prev;
    logic [7:0] e_addr, e_wdata;
    logic       e_wr, e_rd;
    logic [2:0] e_own;
    int         waitc [8];
    int         maxw;

    initial begin
        zero_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_grant", 64'(grant2), 64'h0);
        chk("rst_owner", 64'(owner2), 64'h0);
        chk("rst_busy", 64'(busy2), 64'h0);
        chk("rst_saddr", 64'(saddr2), 64'h0);
        chk("rst_grant8", 64'(grant8), 64'h0);
        rst_n = 1'b1;
        step();

        // req to grant latency, mux, ungranted strobe ignored
        addr2[7:0] = 8'h3C; wdata2[7:0] = 8'h11; wr2 = 2'b01;
        srdata2 = 8'hA5; req2 = 2'b01;
        #1;
        chk("t1_wr_pre", 64'(swr2), 64'h0);
        chk("t1_addr_pre", 64'(saddr2), 64'h0);
        chk("t1_rdata", 64'(rdata2), 64'hA5);
        step();
        chk("t1_grant", 64'(grant2), 64'h1);
        chk("t1_addr", 64'(saddr2), 64'h3C);
        chk("t1_wr", 64'(swr2), 64'h1);
        chk("t1_wdata", 64'(swdata2), 64'h11);
        chk("t1_busy", 64'(busy2), 64'h1);
        req2 = '0; wr2 = '0;
        step();
        chk("t1_rel", 64'(grant2), 64'h0);
        chk("t1_addr0", 64'(saddr2), 64'h0);

        // round-robin handover with no idle gap
        do_reset();
        req2 = 2'b11;
        step();
        chk("t2_first", 64'(grant2), 64'h1);
        req2 = 2'b10;
        step();
        chk("t2_hand", 64'(grant2), 64'h2);
        chk("t2_busy", 64'(busy2), 64'h1);
        chk("t2_owner", 64'(owner2), 64'h1);
        req2 = 2'b11;
        repeat (3) begin
            step();
            chk("t2_wait", 64'(grant2), 64'h2);
        end
        req2 = 2'b01;
        step();
        chk("t2_back", 64'(grant2), 64'h1);
        req2 = 2'b00;
        step();
        chk("t2_idle", 64'(grant2), 64'h0);
        chk("t2_last_own", 64'(owner2), 64'h0);

        // fixed priority
        do_reset();
        req4 = 4'b1110;
        step();
        chk("t3_first", 64'(grant4), 64'h2);
        chk("t3_owner", 64'(owner4), 64'h1);
        req4 = 4'b0100;
        step();
        chk("t3_hand", 64'(grant4), 64'h4);
        req4 = 4'b0101;
        step();
        chk("t3_keep", 64'(grant4), 64'h4);
        req4 = 4'b1001;
        step();
        chk("t3_low", 64'(grant4), 64'h1);

        // bounded tenure and preemption deferred by an active strobe
        do_reset();
        reqh = 2'b01;
        step();
        chk("t4_first", 64'(granth), 64'h1);
        reqh = 2'b11;
        repeat (3) begin
            step();
            chk("t4_hold0", 64'(granth), 64'h1);
        end
        step();
        chk("t4_preempt", 64'(granth), 64'h2);
        repeat (3) begin
            step();
            chk("t4_hold1", 64'(granth), 64'h2);
        end
        wrh = 2'b10;
        repeat (2) begin
            step();
            chk("t4_defer", 64'(granth), 64'h2);
        end
        chk("t4_swr", 64'(swrh), 64'h1);
        wrh = 2'b00;
        step();
        chk("t4_after", 64'(granth), 64'h1);

        // asynchronous reset mid-access
        addrh[7:0] = 8'h80; wrh = 2'b01;
        #1;
        chk("t5_addr", 64'(saddrh), 64'h80);
        chk("t5_wr", 64'(swrh), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_grant", 64'(granth), 64'h0);
        chk("t5_swr", 64'(swrh), 64'h0);
        chk("t5_saddr", 64'(saddrh), 64'h0);
        chk("t5_busy", 64'(busyh), 64'h0);
        zero_inputs();
        step();
        rst_n = 1'b1;
        step();

        // random sweep, 8 masters
        foreach (waitc[i]) waitc[i] = 0;
        maxw = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 3) == 0) req8[i] = ~req8[i];
            wr8     = 8'($urandom);
            rd8     = 8'($urandom);
            addr8   = {$urandom, $urandom};
            wdata8  = {$urandom, $urandom};
            srdata8 = 8'($urandom);
            prev_g   = grant8;
            req_prev = req8;
            step();
            chk("t6_onehot", 64'($onehot0(grant8)), 64'h1);
            e_addr = '0; e_wdata = '0; e_wr = 1'b0; e_rd = 1'b0; e_own = '0;
            for (int i = 0; i < 8; i++) begin
                if (grant8[i]) begin
                    e_addr  = addr8[i*8 +: 8];
                    e_wdata = wdata8[i*8 +: 8];
                    e_wr    = wr8[i];
                    e_rd    = rd8[i];
                    e_own   = 3'(i);
                end
            end
            chk("t6_addr", 64'(saddr8), 64'(e_addr));
            chk("t6_strb", 64'({swr8, srd8}), 64'({e_wr, e_rd}));
            chk("t6_wdata", 64'(swdata8), 64'(e_wdata));
            chk("t6_rdata", 64'(rdata8), 64'(srdata8));
            if (grant8 != '0) chk("t6_owner", 64'(owner8), 64'(e_own));
            chk("t6_busy", 64'(busy8), 64'(grant8 != '0));
            for (int i = 0; i < 8; i++) begin
                if (grant8[i] || !req_prev[i]) waitc[i] = 0;
                else if (grant8 != '0 && grant8 != prev_g) waitc[i]++;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
        end
        chk("t6_fair", 64'(maxw <= 7), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
